// File: rtl/regfile_sb.sv
// Register file with post-reset clearing sweep, per-entry pending (scoreboard) bits,
// and optional same-cycle write-to-read forwarding enabled by REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_addr_1,
  input  logic [ADDR_W-1:0] reg_addr_2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] reg_addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pend_set_en,
  input  logic [ADDR_W-1:0] pend_set_addr,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              ready,
  output logic [DATA_W-1:0] mem_test
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              pend_clr_en;
  logic [ADDR_W-1:0] pend_clr_addr;
  logic              pend_set_ok;

  logic [DATA_W-1:0] rd_1, rd_2, rd_0;
  logic              bz_1, bz_2;

  // Next state plus the single array write port, shared by the sweep and writeback.
  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    mem_we        = 1'b0;
    mem_waddr     = reg_addr_in;
    mem_wdata     = data_in;
    pend_clr_en   = 1'b0;
    pend_clr_addr = reg_addr_in;
    pend_set_ok   = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we        = rst_n;
        mem_waddr     = clr_ptr_q;
        mem_wdata     = '0;
        pend_clr_en   = rst_n;
        pend_clr_addr = clr_ptr_q;
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d = READY;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      READY: begin
        mem_we      = rst_n & write_en;
        pend_clr_en = rst_n & write_en;
        pend_set_ok = rst_n & pend_set_en;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= (state_d == READY);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Set is applied after clear so a new producer wins over a same-cycle writeback.
  always_ff @(posedge clk) begin
    if (pend_clr_en) pend_q[pend_clr_addr] <= 1'b0;
    if (pend_set_ok) pend_q[pend_set_addr] <= 1'b1;
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_1, fwd_2, fwd_0;

  always_comb begin
    fwd_1 = ready_q & write_en & (reg_addr_in == reg_addr_1);
    fwd_2 = ready_q & write_en & (reg_addr_in == reg_addr_2);
    fwd_0 = ready_q & write_en & (reg_addr_in == '0);
    rd_1  = fwd_1 ? data_in : mem[reg_addr_1];
    rd_2  = fwd_2 ? data_in : mem[reg_addr_2];
    rd_0  = fwd_0 ? data_in : mem[0];
    bz_1  = fwd_1 ? (pend_set_en & (pend_set_addr == reg_addr_1)) : pend_q[reg_addr_1];
    bz_2  = fwd_2 ? (pend_set_en & (pend_set_addr == reg_addr_2)) : pend_q[reg_addr_2];
  end
`else
  always_comb begin
    rd_1 = mem[reg_addr_1];
    rd_2 = mem[reg_addr_2];
    rd_0 = mem[0];
    bz_1 = pend_q[reg_addr_1];
    bz_2 = pend_q[reg_addr_2];
  end
`endif

  // Read side is masked until the sweep has finished.
  always_comb begin
    data_out_1 = ready_q ? rd_1 : '0;
    data_out_2 = ready_q ? rd_2 : '0;
    mem_test   = ready_q ? rd_0 : '0;
    busy_1     = ready_q & bz_1;
    busy_2     = ready_q & bz_2;
    ready      = ready_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  reg_addr_1, reg_addr_2, reg_addr_in, pend_set_addr;
  logic        write_en, pend_set_en;
  logic [15:0] data_in;
  logic [15:0] data_out_1, data_out_2, mem_test;
  logic        busy_1, busy_2, ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] d1, d2, mt;
    logic        b1, b2, rdy;
  } exp_t;

  exp_t sb[$];

  regfile_sb #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr_1(reg_addr_1), .reg_addr_2(reg_addr_2),
    .write_en(write_en), .reg_addr_in(reg_addr_in), .data_in(data_in),
    .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
    .data_out_1(data_out_1), .data_out_2(data_out_2),
    .busy_1(busy_1), .busy_2(busy_2), .ready(ready), .mem_test(mem_test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                          input logic b1, input logic b2, input logic rdy, input logic [15:0] mt);
    exp_t e;
    e.tag = tag; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.rdy = rdy; e.mt = mt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".d1"}, data_out_1, e.d1);
      cmp({e.tag, ".d2"}, data_out_2, e.d2);
      cmp({e.tag, ".b1"}, 16'(busy_1), 16'(e.b1));
      cmp({e.tag, ".b2"}, 16'(busy_2), 16'(e.b2));
      cmp({e.tag, ".rdy"}, 16'(ready), 16'(e.rdy));
      cmp({e.tag, ".mt"}, mem_test, e.mt);
    end
  endtask

  // Settle combinational paths, then compare against the expectation just queued.
  task automatic chk(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                     input logic b1, input logic b2, input logic rdy, input logic [15:0] mt);
    push_exp(tag, d1, d2, b1, b2, rdy, mt);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0; write_en = 1'b0; pend_set_en = 1'b0;
    reg_addr_1 = 8'd5; reg_addr_2 = 8'd200; reg_addr_in = 8'd0;
    pend_set_addr = 8'd0; data_in = 16'h0;
    tick(); tick();
    chk("reset", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

    // Initial sweep: ready rises on the 256th edge after release.
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) chk("sweep_255", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      if (i == 256) chk("sweep_256", 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
    end

    write_en = 1'b1; reg_addr_in = 8'd5; data_in = 16'h1234;
    reg_addr_1 = 8'd5; reg_addr_2 = 8'd5;
    chk("wr5_same", BYP ? 16'h1234 : 16'h0, BYP ? 16'h1234 : 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
    tick(); write_en = 1'b0;
    chk("rd5", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0);

    write_en = 1'b1; reg_addr_in = 8'd0; data_in = 16'hBEEF; reg_addr_2 = 8'd0;
    chk("wr0_same", 16'h1234, BYP ? 16'hBEEF : 16'h0, 1'b0, 1'b0, 1'b1, BYP ? 16'hBEEF : 16'h0);
    tick(); write_en = 1'b0;
    chk("rd0", 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF);

    pend_set_en = 1'b1; pend_set_addr = 8'd7; reg_addr_1 = 8'd7;
    chk("pset7_same", 16'h0, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    tick(); pend_set_en = 1'b0;
    chk("busy7", 16'h0, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF);

    write_en = 1'b1; reg_addr_in = 8'd7; data_in = 16'h00AA;
    chk("wr7_same", BYP ? 16'h00AA : 16'h0, 16'hBEEF, !BYP, 1'b0, 1'b1, 16'hBEEF);
    tick(); write_en = 1'b0;
    chk("rd7", 16'h00AA, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF);

    write_en = 1'b1; reg_addr_in = 8'd9; data_in = 16'h0999;
    pend_set_en = 1'b1; pend_set_addr = 8'd9; reg_addr_2 = 8'd9;
    chk("setwr9_same", 16'h00AA, BYP ? 16'h0999 : 16'h0, 1'b0, BYP, 1'b1, 16'hBEEF);
    tick(); write_en = 1'b0; pend_set_en = 1'b0;
    chk("rd9", 16'h00AA, 16'h0999, 1'b0, 1'b1, 1'b1, 16'hBEEF);

    write_en = 1'b1; reg_addr_in = 8'd3; data_in = 16'h5555; reg_addr_1 = 8'd3;
    chk("wr3_same", BYP ? 16'h5555 : 16'h0, 16'h0999, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    tick(); write_en = 1'b0;
    chk("rd3", 16'h5555, 16'h0999, 1'b0, 1'b1, 1'b1, 16'hBEEF);

    // Reset from READY, with writes and pend sets attempted throughout the sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; write_en = 1'b1; reg_addr_in = 8'd0; data_in = 16'hFFFF;
    pend_set_en = 1'b1; pend_set_addr = 8'd10; reg_addr_1 = 8'd0; reg_addr_2 = 8'd10;
    chk("rst_ready", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 50) chk("sweep_mid", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) begin
        chk("restart_255", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        write_en = 1'b0; pend_set_en = 1'b0;
      end
      if (i == 256) chk("restart_256", 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
    end

    reg_addr_1 = 8'd5; reg_addr_2 = 8'd9;
    chk("clr_5_9", 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
    reg_addr_1 = 8'd3; reg_addr_2 = 8'd7;
    chk("clr_3_7", 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);

    write_en = 1'b1; reg_addr_in = 8'd200; data_in = 16'h4321;
    reg_addr_1 = 8'd200; reg_addr_2 = 8'd200;
    tick(); write_en = 1'b0;
    chk("rd200", 16'h4321, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the CPU datapath register file: DATA_W-wide, 2**ADDR_W-deep storage with two asynchronous read ports and one synchronous write port. Adds three behaviours the existing register file lacks: a post-reset clearing sweep, a per-entry pending (scoreboard) bit for the pipeline hazard unit, and compile-time write-to-read forwarding. Sits between the decode stage (reads, pending-bit set) and the writeback stage (writes, pending-bit clear).

## Interface
- DATA_W, 16, data width of each entry
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- reg_addr_1  input  ADDR_W  read port 1 address
- reg_addr_2  input  ADDR_W  read port 2 address
- write_en  input  1  write strobe
- reg_addr_in  input  ADDR_W  write address
- data_in  input  DATA_W  write data
- pend_set_en  input  1  mark entry pending (producer issued)
- pend_set_addr  input  ADDR_W  entry to mark pending
- data_out_1  output  DATA_W  read data, port 1
- data_out_2  output  DATA_W  read data, port 2
- busy_1  output  1  pending bit of reg_addr_1
- busy_2  output  1  pending bit of reg_addr_2
- ready  output  1  high once clearing sweep is complete
- mem_test  output  DATA_W  contents of entry 0, debug

## Operation
- FSM with two states, CLEAR and READY. rst_n low (sampled at clk edge) forces CLEAR, clr_ptr=0, ready=0.
- CLEAR: each cycle with rst_n high writes 0 to mem[clr_ptr], clears pend[clr_ptr], and increments clr_ptr. On the cycle clr_ptr==DEPTH-1, transition to READY. write_en and pend_set_en are ignored in CLEAR.
- READY: write_en=1 writes data_in to mem[reg_addr_in] and clears pend[reg_addr_in]. pend_set_en=1 sets pend[pend_set_addr].
- Same cycle, pend_set_addr==reg_addr_in with both strobes: data is written, pending bit ends SET (the new producer wins).
- Reads are combinational from the array. data_out_*, busy_* and mem_test are forced to 0 while ready=0.
- Both read ports may address the same entry; no restriction.

## Timing
- Reset values: ready=0, data_out_1/2=0, busy_1/2=0, mem_test=0, state=CLEAR, clr_ptr=0.
- Sweep length is exactly DEPTH cycles after the first clk edge with rst_n=1; ready is registered and rises on the following edge (ready=1 at edge DEPTH).
- rst_n asserted mid-sweep restarts the sweep at entry 0. rst_n asserted in READY re-enters CLEAR; array contents are re-zeroed by the sweep.
- Write latency 1 cycle: value visible on read ports the cycle after the write edge (without bypass).
- Pending set/clear take effect at the edge; busy_* reflect the new value from the next cycle.
- clr_ptr is ADDR_W bits and wraps only on reset restart; it never wraps during a sweep.

## Configuration
- REGFILE_BYPASS_EN defined: in READY, if write_en=1 and reg_addr_in equals a read address, that port returns data_in in the same cycle, and its busy_* is 0 unless pend_set_en targets the same address that cycle. mem_test likewise bypasses for reg_addr_in==0.
- Not defined: read ports return the stored (old) value and the current pending bit; there are no same-cycle forwarding paths.

## Test plan
- Reset then release: ready=0 for 256 cycles (ADDR_W=8), rises at edge 256; all reads return 0 and busy_1/2 return 0.
- Write 0x1234 to entry 5, then read via both ports at 5 -> 0x1234 on both ports the next cycle; mem_test stays 0 until entry 0 is written with 0xBEEF, after which it shows 0xBEEF.
- pend_set at entry 7, then read 7 -> busy_1=1; write 0x00AA to entry 7 -> busy_1=0 next cycle and data 0x00AA. Simultaneous set and write on entry 9 -> busy=1, data updated.
- With REGFILE_BYPASS_EN: write 0x5555 to entry 3 while reg_addr_1=3 -> data_out_1=0x5555 in the same cycle. Without the macro: the old value is returned in that cycle and 0x5555 the next cycle.
- Write attempts and pend_set during CLEAR, and rst_n pulse at sweep cycle 100 -> writes ignored, sweep restarts, ready is 0 until 256 cycles after the pulse, and all entries read 0.
